// File: rtl/misc_v_pkg.sv
// Shared ALU definitions: opcode encoding, default widths and the "writes a register" decode,
// used by both the issue stage and the ALU.
package misc_v_pkg;

  localparam int DATA_W_DEF = 16;
  localparam int REG_W_DEF  = 4;
  localparam int OP_W_DEF   = 3;

  typedef enum logic [OP_W_DEF-1:0] {
    NOOP = 3'd0,
    ADD  = 3'd1,
    SUB  = 3'd2,
    OR   = 3'd3,
    AND  = 3'd4,
    RSV5 = 3'd5,
    SHL  = 3'd6,
    RSV7 = 3'd7
  } alu_op_e;

  // Reserved encodings 5 and 7 behave like NOOP: they never produce a register result.
  function automatic logic op_writes_reg(input logic [OP_W_DEF-1:0] op);
    case (op)
      ADD, SUB, OR, AND, SHL: op_writes_reg = 1'b1;
      default:               op_writes_reg = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/alu_scoreboard.sv
// Pending-destination scoreboard: one bit per register, set when a writing instruction leaves
// the issue slot, cleared by writeback. r0 is never pending.
module alu_scoreboard
  import misc_v_pkg::*;
#(
  parameter int REG_W = REG_W_DEF
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             set_en_i,
  input  logic [REG_W-1:0] set_idx_i,
  input  logic             clr_en_i,
  input  logic [REG_W-1:0] clr_idx_i,
  input  logic [REG_W-1:0] src_a_i,
  input  logic [REG_W-1:0] src_b_i,
  output logic             busy_a_o,
  output logic             busy_b_o
);

  localparam int NREG = 1 << REG_W;

  logic [NREG-1:0] pending_q;
  logic [NREG-1:0] pending_d;

  // A set and a clear of the same index in one cycle leave the bit set.
  always_comb begin
    pending_d    = pending_q;
    pending_d[0] = 1'b0;
    for (int i = 1; i < NREG; i++) begin
      if (set_en_i && (set_idx_i == REG_W'(i))) begin
        pending_d[i] = 1'b1;
      end else if (clr_en_i && (clr_idx_i == REG_W'(i))) begin
        pending_d[i] = 1'b0;
      end else begin
        pending_d[i] = pending_q[i];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      pending_q <= '0;
    end else begin
      pending_q <= pending_d;
    end
  end

  // A register being written back this cycle is already resolved for a reader.
  assign busy_a_o = (src_a_i != '0) && pending_q[src_a_i] && !(clr_en_i && (clr_idx_i == src_a_i));
  assign busy_b_o = (src_b_i != '0) && pending_q[src_b_i] && !(clr_en_i && (clr_idx_i == src_b_i));

endmodule

// File: rtl/alu_issue_stage.sv
// ALU issue stage: a single operand slot between decode and the ALU with hazard detection.
// Build option ALU_FORWARD_EN: forward ALU result / writeback data instead of stalling on pending registers.
module alu_issue_stage
  import misc_v_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int REG_W  = REG_W_DEF,
  parameter int OP_W   = OP_W_DEF
) (
  input  logic              CLK,
  input  logic              Reset,
  input  logic              InValid,
  output logic              InReady,
  input  logic [OP_W-1:0]   InOp,
  input  logic [REG_W-1:0]  InDest,
  input  logic [REG_W-1:0]  InSrcA,
  input  logic [REG_W-1:0]  InSrcB,
  input  logic [DATA_W-1:0] InDataA,
  input  logic [DATA_W-1:0] InDataB,
  output logic              OutValid,
  input  logic              OutReady,
  output logic [DATA_W-1:0] FirstInput,
  output logic [DATA_W-1:0] SecondInput,
  output logic [OP_W-1:0]   ALUOp,
  output logic [REG_W-1:0]  OutDest,
  input  logic [DATA_W-1:0] ResultData,
  input  logic              WbValid,
  input  logic [REG_W-1:0]  WbDest,
  input  logic [DATA_W-1:0] WbData
);

  logic              valid_q, valid_d;
  logic [DATA_W-1:0] first_q, first_d;
  logic [DATA_W-1:0] second_q, second_d;
  logic [OP_W-1:0]   op_q, op_d;
  logic [REG_W-1:0]  dest_q, dest_d;

  logic              slot_writes_s;
  logic              out_xfer_s;
  logic              in_xfer_s;
  logic              set_pending_s;
  logic              hit_a_s, hit_b_s;
  logic              busy_a_s, busy_b_s;
  logic              hazard_s;
  logic [DATA_W-1:0] opnd_a_s, opnd_b_s;

  assign slot_writes_s = valid_q && (dest_q != '0) && op_writes_reg(OP_W_DEF'(op_q));
  assign out_xfer_s    = valid_q && OutReady;
  assign set_pending_s = out_xfer_s && slot_writes_s;
  assign hit_a_s       = slot_writes_s && (InSrcA != '0) && (InSrcA == dest_q);
  assign hit_b_s       = slot_writes_s && (InSrcB != '0) && (InSrcB == dest_q);

  alu_scoreboard #(
    .REG_W(REG_W)
  ) u_scoreboard (
    .clk_i    (CLK),
    .reset_i  (Reset),
    .set_en_i (set_pending_s),
    .set_idx_i(dest_q),
    .clr_en_i (WbValid),
    .clr_idx_i(WbDest),
    .src_a_i  (InSrcA),
    .src_b_i  (InSrcB),
    .busy_a_o (busy_a_s),
    .busy_b_o (busy_b_s)
  );

`ifdef ALU_FORWARD_EN
  logic unused_busy_s;
  assign unused_busy_s = busy_a_s ^ busy_b_s;

  // Only a held (not departing) producer stalls; everything else is forwarded, newest first.
  assign hazard_s = (hit_a_s || hit_b_s) && !out_xfer_s;
  assign opnd_a_s = (InSrcA == '0)                     ? '0         :
                    (hit_a_s && out_xfer_s)            ? ResultData :
                    (WbValid && (WbDest == InSrcA))    ? WbData     : InDataA;
  assign opnd_b_s = (InSrcB == '0)                     ? '0         :
                    (hit_b_s && out_xfer_s)            ? ResultData :
                    (WbValid && (WbDest == InSrcB))    ? WbData     : InDataB;
`else
  logic unused_fwd_s;
  assign unused_fwd_s = ^{ResultData, WbData};

  // Without forwarding, wait until the producer's writeback reaches the register file.
  assign hazard_s = hit_a_s || hit_b_s || busy_a_s || busy_b_s;
  assign opnd_a_s = (InSrcA == '0) ? '0 : InDataA;
  assign opnd_b_s = (InSrcB == '0) ? '0 : InDataB;
`endif

  assign InReady   = !Reset && (!valid_q || OutReady) && !hazard_s;
  assign in_xfer_s = InValid && InReady;

  // Slot load takes priority over drain so a simultaneous in/out keeps the slot full.
  always_comb begin
    valid_d  = valid_q;
    first_d  = first_q;
    second_d = second_q;
    op_d     = op_q;
    dest_d   = dest_q;
    if (in_xfer_s) begin
      valid_d  = 1'b1;
      first_d  = opnd_a_s;
      second_d = opnd_b_s;
      op_d     = InOp;
      dest_d   = InDest;
    end else if (out_xfer_s) begin
      valid_d  = 1'b0;
    end else begin
      valid_d  = valid_q;
    end
  end

  always_ff @(posedge CLK) begin
    if (Reset) begin
      valid_q  <= 1'b0;
      first_q  <= '0;
      second_q <= '0;
      op_q     <= '0;
      dest_q   <= '0;
    end else begin
      valid_q  <= valid_d;
      first_q  <= first_d;
      second_q <= second_d;
      op_q     <= op_d;
      dest_q   <= dest_d;
    end
  end

  assign OutValid    = valid_q;
  assign FirstInput  = first_q;
  assign SecondInput = second_q;
  assign ALUOp       = op_q;
  assign OutDest     = dest_q;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Testbench for alu_issue_stage: directed vector table, hazard/forwarding sequences and a
// randomized run against a behavioural model (honours ALU_FORWARD_EN).
module tb_alu_issue_stage;

  logic        CLK = 1'b0;
  logic        Reset, InValid, InReady, OutValid, OutReady, WbValid;
  logic [2:0]  InOp, ALUOp;
  logic [3:0]  InDest, InSrcA, InSrcB, OutDest, WbDest;
  logic [15:0] InDataA, InDataB, FirstInput, SecondInput, ResultData, WbData;

  int total = 0;
  int bad   = 0;

  always #5 CLK = ~CLK;

  alu_issue_stage dut (
    .CLK(CLK), .Reset(Reset), .InValid(InValid), .InReady(InReady),
    .InOp(InOp), .InDest(InDest), .InSrcA(InSrcA), .InSrcB(InSrcB),
    .InDataA(InDataA), .InDataB(InDataB), .OutValid(OutValid), .OutReady(OutReady),
    .FirstInput(FirstInput), .SecondInput(SecondInput), .ALUOp(ALUOp), .OutDest(OutDest),
    .ResultData(ResultData), .WbValid(WbValid), .WbDest(WbDest), .WbData(WbData)
  );

  typedef struct {
    logic        rst, iv;
    logic [2:0]  op;
    logic [3:0]  dst, sa, sb;
    logic [15:0] da, db;
    logic        ordy;
    logic [15:0] res;
    logic        wbv;
    logic [3:0]  wbd;
    logic [15:0] wbdat;
    logic        e_ready, e_valid;
    logic [15:0] e_first, e_second;
    logic [2:0]  e_op;
    logic [3:0]  e_dst;
  } vec_t;

  function automatic vec_t mk(input int rst, iv, op, dst, sa, sb, da, db, ordy, res, wbv, wbd, wbdat,
                              er, ev, ef, es, eo, ed);
    vec_t v;
    v.rst = 1'(rst);    v.iv = 1'(iv);       v.op = 3'(op);       v.dst = 4'(dst);
    v.sa = 4'(sa);      v.sb = 4'(sb);       v.da = 16'(da);      v.db = 16'(db);
    v.ordy = 1'(ordy);  v.res = 16'(res);    v.wbv = 1'(wbv);     v.wbd = 4'(wbd);
    v.wbdat = 16'(wbdat);
    v.e_ready = 1'(er); v.e_valid = 1'(ev);  v.e_first = 16'(ef); v.e_second = 16'(es);
    v.e_op = 3'(eo);    v.e_dst = 4'(ed);
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", name, got, want, $time);
    end
  endtask

  // Drives one cycle of stimulus, checks InReady before the edge and the slot after it.
  task automatic run_vec(input string tag, input vec_t v);
    Reset = v.rst;   InValid = v.iv;  InOp = v.op;     InDest = v.dst;
    InSrcA = v.sa;   InSrcB = v.sb;   InDataA = v.da;  InDataB = v.db;
    OutReady = v.ordy; ResultData = v.res; WbValid = v.wbv; WbDest = v.wbd; WbData = v.wbdat;
    #1;
    check({tag, ".InReady"}, 64'(InReady), 64'(v.e_ready));
    @(posedge CLK);
    #1;
    check({tag, ".OutValid"},    64'(OutValid),    64'(v.e_valid));
    check({tag, ".FirstInput"},  64'(FirstInput),  64'(v.e_first));
    check({tag, ".SecondInput"}, 64'(SecondInput), 64'(v.e_second));
    check({tag, ".ALUOp"},       64'(ALUOp),       64'(v.e_op));
    check({tag, ".OutDest"},     64'(OutDest),     64'(v.e_dst));
    @(negedge CLK);
  endtask

  // Reference model state: the held instruction and the set of registers awaiting writeback.
  logic        m_valid;
  logic [2:0]  m_op;
  logic [3:0]  m_dst;
  logic [15:0] m_a, m_b;
  logic [15:0] m_pend;

  function automatic bit produces(input logic [2:0] op, input logic [3:0] dst);
    return (dst != 4'd0) && (op inside {3'd1, 3'd2, 3'd3, 3'd4, 3'd6});
  endfunction

  function automatic bit slot_makes(input logic [3:0] src);
    return (src != 4'd0) && m_valid && produces(m_op, m_dst) && (m_dst == src);
  endfunction

  vec_t tbl[20];
  vec_t hs[$];

  initial begin
    // Reset, basic issue, back-pressure, r0 handling, reserved opcode.
    tbl[0]  = mk(1,1,1,1,2,3,15,28,1,0,0,0,0,            0,0,0,0,0,0);
    tbl[1]  = tbl[0];
    tbl[2]  = mk(0,1,1,1,2,3,15,28,1,0,0,0,0,            1,1,15,28,1,1);
    tbl[3]  = mk(0,0,0,0,0,0,0,0,1,0,0,0,0,              1,0,15,28,1,1);
    tbl[4]  = mk(0,0,0,0,0,0,0,0,1,0,1,1,43,             1,0,15,28,1,1);
    tbl[5]  = mk(0,1,3,5,6,7,'h00F0,'h0F00,0,0,0,0,0,    1,1,'h00F0,'h0F00,3,5);
    tbl[6]  = mk(0,1,4,8,9,10,'hFFFF,'h0F0F,0,0,0,0,0,   0,1,'h00F0,'h0F00,3,5);
    tbl[7]  = tbl[6];
    tbl[8]  = tbl[6];
    tbl[9]  = mk(0,1,4,8,9,10,'hFFFF,'h0F0F,1,0,0,0,0,   1,1,'hFFFF,'h0F0F,4,8);
    tbl[10] = mk(0,1,1,0,0,11,'h1234,'h0007,1,0,0,0,0,   1,1,0,7,1,0);
    tbl[11] = mk(0,1,2,12,0,0,'h5555,'hAAAA,1,0,0,0,0,   1,1,0,0,2,12);
    tbl[12] = mk(0,0,0,0,0,0,0,0,1,0,0,0,0,              1,0,0,0,2,12);
    tbl[13] = mk(0,0,0,0,0,0,0,0,1,0,1,5,0,              1,0,0,0,2,12);
    tbl[14] = mk(0,0,0,0,0,0,0,0,1,0,1,8,0,              1,0,0,0,2,12);
    tbl[15] = mk(0,0,0,0,0,0,0,0,1,0,1,12,0,             1,0,0,0,2,12);
    tbl[16] = mk(0,1,5,3,1,2,9,10,1,0,0,0,0,             1,1,9,10,5,3);
    tbl[17] = mk(0,1,1,4,3,0,'h77,0,1,0,0,0,0,           1,1,'h77,0,1,4);
    tbl[18] = mk(0,0,0,0,0,0,0,0,1,0,0,0,0,              1,0,'h77,0,1,4);
    tbl[19] = mk(0,0,0,0,0,0,0,0,1,0,1,4,0,              1,0,'h77,0,1,4);

    // add r1=r2+r3 followed by dependent sub r4=r1-r2 (ALU result 43, stale RF value 0x0BAD).
    hs.push_back(mk(0,1,1,1,2,3,15,28,1,0,0,0,0,          1,1,15,28,1,1));
    hs.push_back(mk(0,1,2,4,1,2,'h0BAD,28,0,43,0,0,0,     0,1,15,28,1,1));
`ifdef ALU_FORWARD_EN
    hs.push_back(mk(0,1,2,4,1,2,'h0BAD,28,1,43,0,0,0,     1,1,43,28,2,4));
    hs.push_back(mk(0,0,0,0,0,0,0,0,1,0,1,1,43,           1,0,43,28,2,4));
    hs.push_back(mk(0,0,0,0,0,0,0,0,1,0,1,4,0,            1,0,43,28,2,4));
`else
    hs.push_back(mk(0,1,2,4,1,2,'h0BAD,28,1,43,0,0,0,     0,0,15,28,1,1));
    hs.push_back(mk(0,1,2,4,1,2,'h0BAD,28,1,43,0,0,0,     0,0,15,28,1,1));
    hs.push_back(mk(0,1,2,4,1,2,43,28,1,0,1,1,43,         1,1,43,28,2,4));
    hs.push_back(mk(0,0,0,0,0,0,0,0,1,0,0,0,0,            1,0,43,28,2,4));
    hs.push_back(mk(0,0,0,0,0,0,0,0,1,0,1,4,0,            1,0,43,28,2,4));
`endif

    for (int i = 0; i < 20; i++) run_vec($sformatf("tbl%0d", i), tbl[i]);
    for (int i = 0; i < hs.size(); i++) run_vec($sformatf("seq%0d", i), hs[i]);

    // Randomized run; the first cycle is a reset so the model starts in step with the DUT.
    m_valid = 1'b0; m_op = 3'd0; m_dst = 4'd0; m_a = 16'd0; m_b = 16'd0; m_pend = 16'd0;
    for (int c = 0; c < 3000; c++) begin
      bit          out_go, exp_ready, ha, hb, writes;
      logic [15:0] ea, eb;
      Reset      = (c == 0) || ($urandom_range(0, 99) == 0);
      InValid    = ($urandom_range(0, 9) < 7);
      InOp       = 3'($urandom_range(0, 7));
      InDest     = 4'($urandom_range(0, 5));
      InSrcA     = 4'($urandom_range(0, 5));
      InSrcB     = 4'($urandom_range(0, 5));
      InDataA    = 16'($urandom);
      InDataB    = 16'($urandom);
      OutReady   = ($urandom_range(0, 9) < 6);
      ResultData = 16'($urandom);
      WbValid    = ($urandom_range(0, 9) < 4);
      WbDest     = 4'($urandom_range(0, 5));
      if ($urandom_range(0, 1) == 1) begin
        for (int k = 0; k < 16; k++) if (m_pend[k]) WbDest = 4'(k);
      end
      WbData     = 16'($urandom);
      #1;
      out_go = m_valid && OutReady;
      writes = m_valid && produces(m_op, m_dst);
`ifdef ALU_FORWARD_EN
      ha = slot_makes(InSrcA) && !out_go;
      hb = slot_makes(InSrcB) && !out_go;
      ea = (InSrcA == 4'd0) ? 16'd0 : (slot_makes(InSrcA) && out_go) ? ResultData :
           (WbValid && WbDest == InSrcA) ? WbData : InDataA;
      eb = (InSrcB == 4'd0) ? 16'd0 : (slot_makes(InSrcB) && out_go) ? ResultData :
           (WbValid && WbDest == InSrcB) ? WbData : InDataB;
`else
      ha = slot_makes(InSrcA) || (InSrcA != 4'd0 && m_pend[InSrcA] && !(WbValid && WbDest == InSrcA));
      hb = slot_makes(InSrcB) || (InSrcB != 4'd0 && m_pend[InSrcB] && !(WbValid && WbDest == InSrcB));
      ea = (InSrcA == 4'd0) ? 16'd0 : InDataA;
      eb = (InSrcB == 4'd0) ? 16'd0 : InDataB;
`endif
      exp_ready = !Reset && (!m_valid || OutReady) && !ha && !hb;
      check("rnd.InReady", 64'(InReady), 64'(exp_ready));
      if (Reset) begin
        m_valid = 1'b0; m_op = 3'd0; m_dst = 4'd0; m_a = 16'd0; m_b = 16'd0; m_pend = 16'd0;
      end else begin
        if (WbValid) m_pend[WbDest] = 1'b0;
        if (out_go && writes) m_pend[m_dst] = 1'b1;
        if (InValid && exp_ready) begin
          m_valid = 1'b1; m_op = InOp; m_dst = InDest; m_a = ea; m_b = eb;
        end else if (out_go) begin
          m_valid = 1'b0;
        end
      end
      @(posedge CLK);
      #1;
      check("rnd.slot", 64'({OutValid, ALUOp, OutDest, FirstInput, SecondInput}),
            64'({m_valid, m_op, m_dst, m_a, m_b}));
      @(negedge CLK);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_issue_stage.md
ALU_ISSUE_STAGE -- requirements
Module: alu_issue_stage

Interface
REQ-001 SHALL have parameter DATA_W, default 16, operand/result width.
REQ-002 SHALL have parameter REG_W, default 4, register-index width.
REQ-003 SHALL have parameter OP_W, default 3, ALU opcode width.
REQ-004 SHALL have CLK  in  1  the single clock; all state updates on its rising edge.
REQ-005 SHALL have Reset  in  1  synchronous, active-high reset.
REQ-006 SHALL have InValid  in  1 / InReady  out  1  decoder-side handshake.
REQ-007 SHALL have InOp  in  OP_W / InDest, InSrcA, InSrcB  in  REG_W  decoded opcode, destination and source indices.
REQ-008 SHALL have InDataA, InDataB  in  DATA_W  register-file read data.
REQ-009 SHALL have OutValid  out  1 / OutReady  in  1  ALU-side handshake.
REQ-010 SHALL have FirstInput, SecondInput  out  DATA_W / ALUOp  out  OP_W / OutDest  out  REG_W  registered ALU operands, opcode and destination.
REQ-011 SHALL have ResultData  in  DATA_W  ALU OutputData for the slot currently held.
REQ-012 SHALL have WbValid  in  1 / WbDest  in  REG_W / WbData  in  DATA_W  writeback bus.

Function
REQ-013 SHALL hold one instruction slot; states EMPTY (OutValid=0) and FULL (OutValid=1).
REQ-014 SHALL transfer in when InValid&&InReady, transfer out when OutValid&&OutReady; both in one cycle keeps FULL with the new entry.
REQ-015 SHALL drive InReady = !Reset && (EMPTY || OutReady) && !hazard.
REQ-016 SHALL treat register 0 as constant zero: source index 0 never forwards, never causes a hazard, and captures 0 regardless of InData.
REQ-017 SHALL apply opcodes 0 noop, 1 add, 2 sub, 3 or, 4 and, 6 shl unchanged to ALUOp; opcodes 5, 7 pass through as noop-equivalent (no dest marked).
REQ-018 SHALL latency: accepted instruction appears on outputs the cycle after acceptance; outputs stable while FULL && !OutReady.
REQ-019 SHALL mark destination pending on transfer-out when dest!=0 and op in {1,2,3,4,6}; clear pending on WbValid for WbDest; set and clear same cycle same index -> set wins.
REQ-020 SHALL capture source data by priority: out-transfer this cycle with OutDest==src -> ResultData; else WbValid&&WbDest==src -> WbData; else InData (forwarding build only, see REQ-024).
REQ-021 SHALL assert hazard when a nonzero source equals OutDest of a FULL slot not transferring out this cycle, or equals a pending index not being written back this cycle.

Reset
REQ-022 SHALL, while Reset=1, clear OutValid, FirstInput, SecondInput, ALUOp, OutDest and all pending bits to 0 and hold InReady=0, discarding any in-flight slot.
REQ-023 SHALL accept input on the first cycle after Reset deasserts.

Configuration
REQ-024 SHALL with ALU_FORWARD_EN defined implement REQ-020 forwarding; hazard only per REQ-021 first clause.
REQ-025 SHALL without ALU_FORWARD_EN capture InData only and stall (InReady=0) whenever a nonzero source equals OutDest of a FULL slot or any pending index, until WbValid clears it.

Structure
REQ-026 SHALL take opcode constants (NOOP..SHL) and DATA_W/REG_W/OP_W defaults from shared package misc_v_pkg, reused by ALU.
REQ-027 SHALL place pending bits and their set/clear/lookup logic in sub-module alu_scoreboard.

Verification
REQ-028 Reset=1 for 2 cycles with InValid=1 -> OutValid=0, InReady=0, all outputs 0; first cycle after -> InReady=1.
REQ-029 Issue add r1=r2+r3 (InDataA=15, InDataB=28), OutReady=1 -> next cycle FirstInput=15, SecondInput=28, ALUOp=1, OutDest=1.
REQ-030 ALU_FORWARD_EN: add r1 then sub r4=r1-r2 back-to-back, ResultData=43, InDataB=28 -> second slot FirstInput=43, SecondInput=28, no stall.
REQ-031 No ALU_FORWARD_EN, same pair -> InReady=0 until WbValid=1, WbDest=1; sub accepted that cycle or later with register-file data.
REQ-032 OutReady=0 for 3 cycles while FULL -> outputs stable, InReady=0; OutReady=1 with InValid=1 -> new entry replaces old in one cycle.
REQ-033 Instruction with InSrcA=0, InDataA=0x1234, InDest=0 -> FirstInput=0, no pending bit set, following instruction reading r0 never stalls.
